// File: rtl/instr_prefetch_buffer.sv
// instr_prefetch_buffer
//   Instruction fetch stage between the instruction RAM and decode. Issues
//   sequential word fetches over a req/gnt/rvalid handshake (at most one
//   outstanding request), buffers the returned instructions together with
//   their fetch address in a small FIFO, and restarts at a new target on a
//   branch redirect, discarding buffered and in-flight instructions.
//
// Ports
//   clk_i, rst_ni          clock (rising edge), async active-low reset
//   req_i                  core enables fetching
//   branch_i               single-cycle redirect pulse, target on branch_addr_i
//   ready_i                decode accepts the head instruction
//   valid_o/rdata_o/addr_o FIFO head: valid flag, instruction, fetch address
//   busy_o                 request pending or response outstanding
//   instr_req_o/_addr_o    memory request and address (registered)
//   instr_gnt_i            memory grant
//   instr_rvalid_i/_rdata_i memory response
module instr_prefetch_buffer #(
  parameter int unsigned DEPTH     = 4,
  parameter logic [31:0] BOOT_ADDR = 32'h0000_0000,
  parameter logic [31:0] ADDR_INCR = 32'd1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_i,
  input  logic        branch_i,
  input  logic [31:0] branch_addr_i,
  input  logic        ready_i,
  output logic        valid_o,
  output logic [31:0] rdata_o,
  output logic [31:0] addr_o,
  output logic        busy_o,
  output logic        instr_req_o,
  output logic [31:0] instr_addr_o,
  input  logic        instr_gnt_i,
  input  logic        instr_rvalid_i,
  input  logic [31:0] instr_rdata_i
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] DepthCnt = CntW'(DEPTH);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StReq   = 2'd1;
  localparam logic [1:0] StWait  = 2'd2;
  localparam logic [1:0] StFlush = 2'd3;

  logic [1:0]      state_q, state_d;
  logic [31:0]     fetchAddr_q, fetchAddr_d;
  logic [31:0]     reqAddr_q, reqAddr_d;
  logic            reqOut_q;
  logic            busy_q;
  logic [31:0]     fifoData_q [DEPTH];
  logic [31:0]     fifoAddr_q [DEPTH];
  logic [PtrW-1:0] wrPtr_q, rdPtr_q;
  logic [CntW-1:0] count_q;
  logic [CntW-1:0] countAfter;
  logic            spaceAfter;
  logic            push;
  logic            pop;
  logic [31:0]     pushAddr;

  // Head of the FIFO; data/address are forced to zero when empty so the
  // outputs never show stale entries left behind by a flush.
  assign valid_o      = (count_q != '0);
  assign rdata_o      = valid_o ? fifoData_q[rdPtr_q] : 32'h0;
  assign addr_o       = valid_o ? fifoAddr_q[rdPtr_q] : 32'h0;
  assign busy_o       = busy_q;
  assign instr_req_o  = reqOut_q;
  assign instr_addr_o = fetchAddr_q;

  always_comb begin
    state_d     = state_q;
    fetchAddr_d = fetchAddr_q;
    reqAddr_d   = reqAddr_q;
    push        = 1'b0;
    pushAddr    = fetchAddr_q;
    pop         = valid_o && ready_i && !branch_i;

    // A response is only accepted when it belongs to our single outstanding
    // request; a branch in the same cycle drops it.
    case (state_q)
      StReq: begin
        if (instr_gnt_i) begin
          fetchAddr_d = fetchAddr_q + ADDR_INCR;
          reqAddr_d   = fetchAddr_q;
          push        = instr_rvalid_i && !branch_i;
        end
      end
      StWait: begin
        if (instr_rvalid_i) begin
          push     = !branch_i;
          pushAddr = reqAddr_q;
        end
      end
      default: ;
    endcase

    // Occupancy after this cycle's push/pop decides whether another request
    // may be issued, which is what keeps the FIFO from ever overflowing.
    countAfter = count_q + CntW'(push) - CntW'(pop);
    spaceAfter = (countAfter < DepthCnt);

    case (state_q)
      StIdle: begin
        if (req_i && (count_q < DepthCnt)) state_d = StReq;
      end
      StReq: begin
        if (instr_gnt_i) begin
          if (instr_rvalid_i) state_d = (req_i && spaceAfter) ? StReq : StIdle;
          else                state_d = StWait;
        end
      end
      StWait, StFlush: begin
        if (instr_rvalid_i) state_d = (req_i && spaceAfter) ? StReq : StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Redirect overrides everything. If a granted response is still in
    // flight we must swallow it in FLUSH before issuing the new request.
    // A redirect landing in FLUSH together with the awaited rvalid has
    // nothing left to swallow, so it goes straight to REQ.
    if (branch_i) begin
      fetchAddr_d = branch_addr_i;
      case (state_q)
        StReq:   state_d = (instr_gnt_i && !instr_rvalid_i) ? StFlush : StReq;
        StWait:  state_d = instr_rvalid_i ? StReq : StFlush;
        StFlush: state_d = instr_rvalid_i ? StReq : StFlush;
        default: state_d = StReq;
      endcase
    end
  end

  // Control state, FIFO pointers and registered request/busy outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      fetchAddr_q <= BOOT_ADDR;
      reqAddr_q   <= BOOT_ADDR;
      reqOut_q    <= 1'b0;
      busy_q      <= 1'b0;
      wrPtr_q     <= '0;
      rdPtr_q     <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      fetchAddr_q <= fetchAddr_d;
      reqAddr_q   <= reqAddr_d;
      reqOut_q    <= (state_d == StReq);
      busy_q      <= (state_d != StIdle);
      if (branch_i) begin
        wrPtr_q <= '0;
        rdPtr_q <= '0;
        count_q <= '0;
      end else begin
        if (push) wrPtr_q <= wrPtr_q + PtrW'(1);
        if (pop)  rdPtr_q <= rdPtr_q + PtrW'(1);
        count_q <= countAfter;
      end
    end
  end

  // FIFO storage needs no reset: entries are only visible while counted.
  always_ff @(posedge clk_i) begin
    if (push) begin
      fifoData_q[wrPtr_q] <= instr_rdata_i;
      fifoAddr_q[wrPtr_q] <= pushAddr;
    end
  end

endmodule

// File: tb/tb_instr_prefetch_buffer.sv
// tb_instr_prefetch_buffer
//   Directed bench for instr_prefetch_buffer. A behavioural instruction
//   memory (configurable grant and response latency, mem[a] = a + 0x100)
//   answers the DUT; the bench keeps its own fetch-address model and pushes
//   expected {addr, data} pairs into a scoreboard queue, which is popped
//   whenever decode accepts an instruction.
module tb_instr_prefetch_buffer;

  logic        clk_i;
  logic        rst_ni;
  logic        req_i;
  logic        branch_i;
  logic [31:0] branch_addr_i;
  logic        ready_i;
  logic        valid_o;
  logic [31:0] rdata_o;
  logic [31:0] addr_o;
  logic        busy_o;
  logic        instr_req_o;
  logic [31:0] instr_addr_o;
  logic        instr_gnt_i;
  logic        instr_rvalid_i;
  logic [31:0] instr_rdata_i;

  instr_prefetch_buffer #(
    .DEPTH    (4),
    .BOOT_ADDR(32'h0000_0000),
    .ADDR_INCR(32'd1)
  ) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .req_i         (req_i),
    .branch_i      (branch_i),
    .branch_addr_i (branch_addr_i),
    .ready_i       (ready_i),
    .valid_o       (valid_o),
    .rdata_o       (rdata_o),
    .addr_o        (addr_o),
    .busy_o        (busy_o),
    .instr_req_o   (instr_req_o),
    .instr_addr_o  (instr_addr_o),
    .instr_gnt_i   (instr_gnt_i),
    .instr_rvalid_i(instr_rvalid_i),
    .instr_rdata_i (instr_rdata_i)
  );

  // Memory model and scoreboard state
  bit          memAuto;
  bit          deadMode;
  bit          pendDiscard;
  int          gntDelay;
  int          rvDelay;
  int          waitCnt;
  int          outCnt;
  int          grantCnt;
  int          popCnt;
  logic [31:0] modelAddr;
  logic [31:0] pendAddr;
  logic [31:0] pendData;
  logic [63:0] expEntry;
  logic [63:0] expQ[$];
  int          nAsserts;
  int          nFails;
  int          g0;
  int          p0;

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    nAsserts++;
    assert (observed === expected) else begin
      nFails++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Drives the core-side inputs just after a rising edge and holds them for
  // the given number of cycles; branch is always a one-cycle pulse.
  task automatic applyStimulus(input logic req, input logic ready, input logic br,
                               input logic [31:0] baddr, input int cycles);
    req_i         = req;
    ready_i       = ready;
    branch_i      = br;
    branch_addr_i = baddr;
    repeat (cycles) begin
      @(posedge clk_i);
      #1;
    end
    branch_i = 1'b0;
  endtask

  // Memory responder plus scoreboard, evaluated on the falling edge where
  // all DUT outputs and bench-driven inputs are stable.
  always @(negedge clk_i) begin
    if (!rst_ni) begin
      waitCnt     = 0;
      outCnt      = -1;
      pendDiscard = 1'b0;
      modelAddr   = 32'h0;
      expQ.delete();
      if (memAuto) begin
        instr_gnt_i    = 1'b0;
        instr_rvalid_i = 1'b0;
      end
    end else begin
      if (memAuto) begin
        instr_gnt_i    = 1'b0;
        instr_rvalid_i = 1'b0;
        if (outCnt == 0) begin
          instr_rvalid_i = 1'b1;
          instr_rdata_i  = pendData;
          outCnt         = -1;
          if (!pendDiscard && !branch_i) expQ.push_back({pendAddr, pendAddr + 32'h100});
          pendDiscard = 1'b0;
        end else if (outCnt > 0) begin
          outCnt--;
          if (branch_i) pendDiscard = 1'b1;
        end
        if (instr_req_o) begin
          checkOutput("fetchAddr", 64'(instr_addr_o), 64'(modelAddr));
          if (waitCnt >= gntDelay) begin
            instr_gnt_i = 1'b1;
            waitCnt     = 0;
            grantCnt++;
            pendAddr = modelAddr;
            pendData = deadMode ? 32'h0000_DEAD : instr_addr_o + 32'h100;
            if (rvDelay == 0) begin
              instr_rvalid_i = 1'b1;
              instr_rdata_i  = pendData;
              if (!branch_i) expQ.push_back({pendAddr, pendAddr + 32'h100});
            end else begin
              outCnt      = rvDelay - 1;
              pendDiscard = branch_i;
            end
            modelAddr = modelAddr + 32'd1;
          end else begin
            waitCnt++;
          end
        end
      end
      if (branch_i) begin
        expQ.delete();
        modelAddr = branch_addr_i;
      end else if (valid_o && ready_i) begin
        if (expQ.size() == 0) begin
          checkOutput("spuriousValid", 64'(valid_o), 64'd0);
        end else begin
          expEntry = expQ.pop_front();
          checkOutput("headAddr", 64'(addr_o), 64'(expEntry[63:32]));
          checkOutput("headData", 64'(rdata_o), 64'(expEntry[31:0]));
          popCnt++;
        end
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_ni         = 1'b0;
    req_i          = 1'b0;
    branch_i       = 1'b0;
    branch_addr_i  = 32'h0;
    ready_i        = 1'b1;
    instr_gnt_i    = 1'b0;
    instr_rvalid_i = 1'b0;
    instr_rdata_i  = 32'h0;
    memAuto        = 1'b1;
    deadMode       = 1'b0;
    pendDiscard    = 1'b0;
    gntDelay       = 0;
    rvDelay        = 0;
    waitCnt        = 0;
    outCnt         = -1;
    grantCnt       = 0;
    popCnt         = 0;
    modelAddr      = 32'h0;
    nAsserts       = 0;
    nFails         = 0;

    // Reset values
    repeat (3) @(posedge clk_i);
    #1;
    checkOutput("rstReq",   64'(instr_req_o),  64'd0);
    checkOutput("rstAddr",  64'(instr_addr_o), 64'd0);
    checkOutput("rstValid", 64'(valid_o),      64'd0);
    checkOutput("rstRdata", 64'(rdata_o),      64'd0);
    checkOutput("rstAddrO", 64'(addr_o),       64'd0);
    checkOutput("rstBusy",  64'(busy_o),       64'd0);

    // Zero-latency streaming from the boot address
    $display("[TB] streaming with zero-latency memory");
    rst_ni = 1'b1;
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 1);
    checkOutput("firstReq", 64'(instr_req_o), 64'd1);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 11);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 6);
    checkOutput("streamPops",    64'(popCnt >= 10),  64'd1);
    checkOutput("streamDrained", 64'(expQ.size()),   64'd0);
    checkOutput("streamIdle",    64'(busy_o),        64'd0);

    // Back-pressure: FIFO fills to DEPTH, then one pop allows one refetch
    $display("[TB] back-pressure");
    g0 = grantCnt;
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 10);
    checkOutput("bpGrants", 64'(grantCnt - g0), 64'd4);
    checkOutput("bpReqLow", 64'(instr_req_o),   64'd0);
    checkOutput("bpValid",  64'(valid_o),       64'd1);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 1);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 5);
    checkOutput("bpRefill",  64'(grantCnt - g0), 64'd5);
    checkOutput("bpReqLow2", 64'(instr_req_o),   64'd0);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 8);
    checkOutput("bpDrained", 64'(expQ.size()), 64'd0);

    // Slow memory: grant after 3 cycles, response 2 cycles after grant
    $display("[TB] delayed memory");
    gntDelay = 3;
    rvDelay  = 2;
    p0       = popCnt;
    for (int i = 0; i < 24; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 1);
      checkOutput("busyDelayed", 64'(busy_o), 64'd1);
    end
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 16);
    checkOutput("slowPops",    64'(popCnt - p0 >= 3), 64'd1);
    checkOutput("slowDrained", 64'(expQ.size()),      64'd0);
    checkOutput("slowIdle",    64'(busy_o),           64'd0);

    // Branch while waiting for a response carrying 0xDEAD
    $display("[TB] branch during WAIT");
    gntDelay = 0;
    rvDelay  = 3;
    deadMode = 1'b1;
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 2);
    deadMode = 1'b0;
    applyStimulus(1'b1, 1'b1, 1'b1, 32'h40, 1);
    checkOutput("brEmpty",   64'(valid_o),     64'd0);
    checkOutput("brNoReq",   64'(instr_req_o), 64'd0);
    checkOutput("brBusy",    64'(busy_o),      64'd1);
    for (int i = 0; i < 10 && !instr_req_o; i++) applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 1);
    checkOutput("brTargetReq",  64'(instr_req_o),  64'd1);
    checkOutput("brTargetAddr", 64'(instr_addr_o), 64'h40);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 4);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 12);
    checkOutput("brDrained", 64'(expQ.size()), 64'd0);

    // Branch coincident with a push and a pop
    $display("[TB] branch with push and pop");
    rvDelay = 0;
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 4);
    checkOutput("bppPreValid", 64'(valid_o), 64'd1);
    applyStimulus(1'b1, 1'b1, 1'b1, 32'h200, 1);
    checkOutput("bppEmpty", 64'(valid_o),      64'd0);
    checkOutput("bppReq",   64'(instr_req_o),  64'd1);
    checkOutput("bppAddr",  64'(instr_addr_o), 64'h200);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 5);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 6);
    checkOutput("bppDrained", 64'(expQ.size()), 64'd0);

    // Fetch address wrap-around
    $display("[TB] address wrap");
    applyStimulus(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFF, 1);
    checkOutput("wrapFirst", 64'(instr_addr_o), 64'hFFFF_FFFF);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 1);
    checkOutput("wrapNext", 64'(instr_addr_o), 64'd0);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 3);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 6);
    checkOutput("wrapDrained", 64'(expQ.size()), 64'd0);

    // Reset pulse while a response is outstanding, then a stray rvalid
    $display("[TB] reset during WAIT");
    rvDelay = 3;
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 2);
    checkOutput("preRstBusy", 64'(busy_o), 64'd1);
    memAuto        = 1'b0;
    instr_gnt_i    = 1'b0;
    instr_rvalid_i = 1'b0;
    req_i          = 1'b0;
    rst_ni         = 1'b0;
    #1;
    checkOutput("midRstReq",   64'(instr_req_o),  64'd0);
    checkOutput("midRstAddr",  64'(instr_addr_o), 64'd0);
    checkOutput("midRstBusy",  64'(busy_o),       64'd0);
    checkOutput("midRstValid", 64'(valid_o),      64'd0);
    checkOutput("midRstRdata", 64'(rdata_o),      64'd0);
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    @(negedge clk_i);
    instr_rvalid_i = 1'b1;
    instr_rdata_i  = 32'hBAD0_0BAD;
    @(posedge clk_i);
    #1;
    instr_rvalid_i = 1'b0;
    checkOutput("strayValid", 64'(valid_o),     64'd0);
    checkOutput("strayBusy",  64'(busy_o),      64'd0);
    checkOutput("strayReq",   64'(instr_req_o), 64'd0);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 2);
    checkOutput("strayValid2", 64'(valid_o), 64'd0);

    // Recovery from the boot address after the reset pulse
    memAuto  = 1'b1;
    gntDelay = 0;
    rvDelay  = 0;
    p0       = popCnt;
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 6);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 6);
    checkOutput("recoverPops",    64'(popCnt - p0 >= 4), 64'd1);
    checkOutput("recoverDrained", 64'(expQ.size()),      64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
    $finish;
  end

endmodule
